// File: rtl/rx_pcs_pkg.sv
// rtl/rx_pcs_pkg.sv - 64B/66B receive constants, block classes and decoder state encoding
package rx_pcs_pkg;

  localparam int LEN_CODED_BLOCK = 66;
  localparam int LEN_RX_DATA     = 64;
  localparam int LEN_RX_CTRL     = 8;
  localparam int LEN_ERR_CNT     = 16;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [7:0] BT_IDLE  = 8'h1E;
  localparam logic [7:0] BT_OSEQ  = 8'h4B;
  localparam logic [7:0] BT_START = 8'h78;
  localparam logic [7:0] BT_T0    = 8'h87;
  localparam logic [7:0] BT_T1    = 8'h99;
  localparam logic [7:0] BT_T2    = 8'hAA;
  localparam logic [7:0] BT_T3    = 8'hB4;
  localparam logic [7:0] BT_T4    = 8'hCC;
  localparam logic [7:0] BT_T5    = 8'hD2;
  localparam logic [7:0] BT_T6    = 8'hE1;
  localparam logic [7:0] BT_T7    = 8'hFF;

  localparam logic [7:0] MII_IDLE  = 8'h07;
  localparam logic [7:0] MII_START = 8'hFB;
  localparam logic [7:0] MII_TERM  = 8'hFD;
  localparam logic [7:0] MII_ERROR = 8'hFE;
  localparam logic [7:0] MII_SEQ   = 8'h9C;

  localparam logic [6:0] PCS_IDLE  = 7'h00;
  localparam logic [6:0] PCS_ERROR = 7'h1E;

  localparam logic [63:0] LBLOCK_DATA = 64'h9C00_0001_0707_0707;
  localparam logic [7:0]  LBLOCK_CTRL = 8'b1000_1111;
  localparam logic [63:0] EBLOCK_DATA = {8{MII_ERROR}};
  localparam logic [7:0]  EBLOCK_CTRL = 8'hFF;

  typedef enum logic [2:0] {
    RX_INIT = 3'd0,
    RX_C    = 3'd1,
    RX_D    = 3'd2,
    RX_T    = 3'd3,
    RX_E    = 3'd4
  } rx_state_e;

  typedef enum logic [2:0] {
    BLK_C = 3'd0,
    BLK_S = 3'd1,
    BLK_T = 3'd2,
    BLK_D = 3'd3,
    BLK_E = 3'd4
  } blk_type_e;

endpackage

// File: rtl/rx_block_classifier.sv
// rtl/rx_block_classifier.sv - combinational class (C/S/T/D/E) and terminate byte count of one 66b block
module rx_block_classifier
  import rx_pcs_pkg::*;
(
  input  logic [65:0] i_block,
  output logic [2:0]  o_type,
  output logic [2:0]  o_t_bytes
);

  logic codes_ok;

  always_comb begin
    codes_ok  = 1'b1;
    o_type    = BLK_E;
    o_t_bytes = 3'd0;
    // An idle block is only valid when every 7b code is idle or error
    for (int k = 0; k < 8; k++) begin
      if (i_block[55-7*k -: 7] != PCS_IDLE && i_block[55-7*k -: 7] != PCS_ERROR)
        codes_ok = 1'b0;
    end
    if (i_block[65:64] == SYNC_DATA) begin
      o_type = BLK_D;
    end else if (i_block[65:64] == SYNC_CTRL) begin
      case (i_block[63:56])
        BT_IDLE:  o_type = codes_ok ? BLK_C : BLK_E;
        BT_OSEQ:  o_type = BLK_C;
        BT_START: o_type = BLK_S;
        BT_T0:    begin o_type = BLK_T; o_t_bytes = 3'd0; end
        BT_T1:    begin o_type = BLK_T; o_t_bytes = 3'd1; end
        BT_T2:    begin o_type = BLK_T; o_t_bytes = 3'd2; end
        BT_T3:    begin o_type = BLK_T; o_t_bytes = 3'd3; end
        BT_T4:    begin o_type = BLK_T; o_t_bytes = 3'd4; end
        BT_T5:    begin o_type = BLK_T; o_t_bytes = 3'd5; end
        BT_T6:    begin o_type = BLK_T; o_t_bytes = 3'd6; end
        BT_T7:    begin o_type = BLK_T; o_t_bytes = 3'd7; end
        default:  o_type = BLK_E;
      endcase
    end
  end

endmodule

// File: rtl/rx_decoder.sv
// rtl/rx_decoder.sv - 64B/66B receive state machine producing one decoded 64b/8b column per enabled block
module rx_decoder
  import rx_pcs_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_block_lock,
  input  logic        i_hi_ber,
  input  logic [65:0] i_rx_coded,
  input  logic [65:0] i_rx_coded_next,
  output logic [63:0] o_rx_data,
  output logic [7:0]  o_rx_ctrl,
  output logic [2:0]  o_rx_state,
  output logic [15:0] o_err_count
);

  rx_state_e   state_q, state_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [15:0] err_q, err_d;

  logic [2:0]  cur_type_raw, nxt_type_raw;
  logic [2:0]  cur_t_bytes, nxt_t_bytes_unused;
  blk_type_e   cur_type, nxt_type;
  logic        term_ok;
  logic [63:0] t_payload;

  rx_block_classifier u_cls_cur (
    .i_block   (i_rx_coded),
    .o_type    (cur_type_raw),
    .o_t_bytes (cur_t_bytes)
  );

  rx_block_classifier u_cls_nxt (
    .i_block   (i_rx_coded_next),
    .o_type    (nxt_type_raw),
    .o_t_bytes (nxt_t_bytes_unused)
  );

  assign cur_type  = blk_type_e'(cur_type_raw);
  assign nxt_type  = blk_type_e'(nxt_type_raw);
  // A terminate is only trusted when the block after it starts a new frame or is idle
  assign term_ok   = (cur_type == BLK_T) && (nxt_type == BLK_S || nxt_type == BLK_C);
  assign t_payload = {i_rx_coded[55:0], 8'h00};

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    err_d   = err_q;
    if (i_enable) begin
      if (!i_block_lock || i_hi_ber) begin
        state_d = RX_INIT;
      end else begin
        case (state_q)
          RX_D: begin
            if (cur_type == BLK_D) state_d = RX_D;
            else if (term_ok)      state_d = RX_T;
            else                   state_d = RX_E;
          end
          RX_E: begin
            if (cur_type == BLK_C)      state_d = RX_C;
            else if (cur_type == BLK_D) state_d = RX_D;
            else if (term_ok)           state_d = RX_T;
            else                        state_d = RX_E;
          end
          default: begin
            if (cur_type == BLK_C)      state_d = RX_C;
            else if (cur_type == BLK_S) state_d = RX_D;
            else                        state_d = RX_E;
          end
        endcase
      end

      case (state_d)
        RX_C: begin
          if (i_rx_coded[63:56] == BT_IDLE) begin
            ctrl_d = 8'hFF;
            for (int k = 0; k < 8; k++)
              data_d[63-8*k -: 8] = (i_rx_coded[55-7*k -: 7] == PCS_IDLE) ? MII_IDLE : MII_ERROR;
          end else begin
            data_d = {MII_SEQ, i_rx_coded[55:32], {4{MII_IDLE}}};
            ctrl_d = 8'b1000_1111;
          end
        end
        RX_D: begin
          if (cur_type == BLK_S) begin
            data_d = {MII_START, i_rx_coded[55:0]};
            ctrl_d = 8'h80;
          end else begin
            data_d = i_rx_coded[63:0];
            ctrl_d = 8'h00;
          end
        end
        RX_T: begin
          for (int k = 0; k < 8; k++) begin
            if (k < int'(cur_t_bytes)) begin
              data_d[63-8*k -: 8] = t_payload[63-8*k -: 8];
              ctrl_d[7-k]         = 1'b0;
            end else begin
              data_d[63-8*k -: 8] = (k == int'(cur_t_bytes)) ? MII_TERM : MII_IDLE;
              ctrl_d[7-k]         = 1'b1;
            end
          end
        end
        RX_E: begin
          data_d = EBLOCK_DATA;
          ctrl_d = EBLOCK_CTRL;
        end
        default: begin
          data_d = LBLOCK_DATA;
          ctrl_d = LBLOCK_CTRL;
        end
      endcase

      if (state_d == RX_E && err_q != 16'hFFFF)
        err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= RX_INIT;
      data_q  <= LBLOCK_DATA;
      ctrl_q  <= LBLOCK_CTRL;
      err_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      err_q   <= err_d;
    end
  end

  assign o_rx_data   = data_q;
  assign o_rx_ctrl   = ctrl_q;
  assign o_rx_state  = state_q;
  assign o_err_count = err_q;

endmodule

// File: tb/tb_rx_decoder.sv
// tb/tb_rx_decoder.sv - directed and random checks of rx_decoder against a byte-level reference model
module tb_rx_decoder;

  localparam int S_INIT = 0, S_C = 1, S_D = 2, S_T = 3, S_E = 4;
  localparam int K_C = 0, K_S = 1, K_T = 2, K_D = 3, K_E = 4;

  logic        clk = 1'b0;
  logic        rst, en, lock, ber;
  logic [65:0] cur, nxt;
  logic [63:0] rx_data;
  logic [7:0]  rx_ctrl;
  logic [2:0]  rx_state;
  logic [15:0] err_count;

  int          checks = 0;
  int          errors = 0;

  int          m_state;
  logic [63:0] m_data;
  logic [7:0]  m_ctrl;
  int          m_cnt;

  logic [7:0]  t_types [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

  always #5 clk = ~clk;

  rx_decoder dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .i_block_lock    (lock),
    .i_hi_ber        (ber),
    .i_rx_coded      (cur),
    .i_rx_coded_next (nxt),
    .o_rx_data       (rx_data),
    .o_rx_ctrl       (rx_ctrl),
    .o_rx_state      (rx_state),
    .o_err_count     (err_count)
  );

  function automatic int classify(input logic [65:0] b, output int nbytes);
    logic [7:0] ty;
    ty = b[63:56];
    nbytes = 0;
    if (b[65:64] == 2'b01) return K_D;
    if (b[65:64] != 2'b10) return K_E;
    if (ty == 8'h4B) return K_C;
    if (ty == 8'h78) return K_S;
    if (ty == 8'h1E) begin
      for (int k = 0; k < 8; k++) begin
        logic [6:0] code;
        code = 7'((b[55:0] >> (49 - 7*k)) & 56'h7F);
        if (code != 7'h00 && code != 7'h1E) return K_E;
      end
      return K_C;
    end
    for (int i = 0; i < 8; i++)
      if (ty == t_types[i]) begin
        nbytes = i;
        return K_T;
      end
    return K_E;
  endfunction

  function automatic logic [63:0] pack(input logic [7:0] lane [8]);
    logic [63:0] r = '0;
    for (int k = 0; k < 8; k++) r = (r << 8) | 64'(lane[k]);
    return r;
  endfunction

  task automatic model_update(input logic [65:0] b, input logic [65:0] bn, input logic e, input logic lk, input logic hb);
    int ct, nt, n, nn, ns;
    logic [7:0] lane [8];
    logic [63:0] pl;
    if (!e) return;
    ct = classify(b, n);
    nt = classify(bn, nn);
    pl = b[63:0];
    if (!lk || hb) ns = S_INIT;
    else if (m_state == S_D)
      ns = (ct == K_D) ? S_D : (ct == K_T && (nt == K_S || nt == K_C)) ? S_T : S_E;
    else if (m_state == S_E)
      ns = (ct == K_C) ? S_C : (ct == K_D) ? S_D : (ct == K_T && (nt == K_S || nt == K_C)) ? S_T : S_E;
    else
      ns = (ct == K_C) ? S_C : (ct == K_S) ? S_D : S_E;
    m_state = ns;
    case (ns)
      S_INIT: begin m_data = 64'h9C00000107070707; m_ctrl = 8'h8F; end
      S_E:    begin m_data = 64'hFEFEFEFEFEFEFEFE; m_ctrl = 8'hFF; end
      S_D: begin
        if (ct == K_S) begin m_data = {8'hFB, pl[55:0]}; m_ctrl = 8'h80; end
        else begin m_data = pl; m_ctrl = 8'h00; end
      end
      S_C: begin
        if (pl[63:56] == 8'h1E) begin
          for (int k = 0; k < 8; k++)
            lane[k] = (((pl[55:0] >> (49 - 7*k)) & 56'h7F) == 0) ? 8'h07 : 8'hFE;
          m_ctrl = 8'hFF;
        end else begin
          lane[0] = 8'h9C;
          for (int k = 1; k < 8; k++) lane[k] = (k < 4) ? pl[63 - 8*k -: 8] : 8'h07;
          m_ctrl = 8'h8F;
        end
        m_data = pack(lane);
      end
      default: begin
        m_ctrl = 8'h00;
        for (int k = 0; k < 8; k++) begin
          if (k < n) lane[k] = pl[55 - 8*k -: 8];
          else begin
            lane[k] = (k == n) ? 8'hFD : 8'h07;
            m_ctrl[7-k] = 1'b1;
          end
        end
        m_data = pack(lane);
      end
    endcase
    if (ns == S_E && m_cnt < 65535) m_cnt++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 64'(rx_state), 64'(m_state));
    chk({tag, ".data"}, rx_data, m_data);
    chk({tag, ".ctrl"}, 64'(rx_ctrl), 64'(m_ctrl));
    chk({tag, ".errcnt"}, 64'(err_count), 64'(m_cnt));
  endtask

  task automatic step(input logic [65:0] b, input logic [65:0] bn, input logic e, input logic lk,
                      input logic hb, input string tag);
    cur = b; nxt = bn; en = e; lock = lk; ber = hb;
    model_update(b, bn, e, lk, hb);
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; en = 1'b1; lock = 1'b1; ber = 1'b0;
    cur = {2'b10, 8'h78, 56'h11223344556677}; nxt = cur;
    repeat (2) @(posedge clk);
    #1;
    m_state = S_INIT; m_data = 64'h9C00000107070707; m_ctrl = 8'h8F; m_cnt = 0;
    check_all(tag);
    rst = 1'b0;
  endtask

  function automatic logic [65:0] mk_d();
    return {2'b01, $urandom, $urandom};
  endfunction
  function automatic logic [65:0] mk_idle();
    return {2'b10, 8'h1E, 56'h0};
  endfunction
  function automatic logic [65:0] mk_s();
    logic [63:0] r = {$urandom, $urandom};
    return {2'b10, 8'h78, r[55:0]};
  endfunction
  function automatic logic [65:0] mk_t(input int n);
    logic [63:0] r = {$urandom, $urandom};
    return {2'b10, t_types[n], r[55:0]};
  endfunction

  function automatic logic [65:0] rand_block();
    logic [63:0] r = {$urandom, $urandom};
    logic [55:0] codes;
    case ($urandom_range(0, 9))
      0, 1, 2: return {2'b01, r};
      3: begin
        for (int k = 0; k < 8; k++)
          codes[55-7*k -: 7] = ($urandom_range(0, 1) != 0) ? 7'h1E : 7'h00;
        if ($urandom_range(0, 7) == 0) codes[20:14] = 7'h2D;
        return {2'b10, 8'h1E, codes};
      end
      4: return {2'b10, 8'h4B, r[55:0]};
      5: return {2'b10, 8'h78, r[55:0]};
      6, 7: return {2'b10, t_types[$urandom_range(0, 7)], r[55:0]};
      8: return {2'b10, r[63:56], r[55:0]};
      default: return {($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, r};
    endcase
  endfunction

  logic [65:0] seq [7];
  logic [65:0] blk, blk_n;

  initial begin
    en = 1'b0; lock = 1'b1; ber = 1'b0; rst = 1'b1;
    cur = '0; nxt = '0;
    m_state = S_INIT; m_data = '0; m_ctrl = '0; m_cnt = 0;

    do_reset("reset");

    step(mk_idle(), mk_idle(), 1'b1, 1'b1, 1'b0, "idle");

    seq[0] = mk_idle(); seq[1] = mk_s(); seq[2] = mk_d(); seq[3] = mk_d();
    seq[4] = mk_t(7); seq[5] = mk_idle(); seq[6] = mk_idle();
    for (int i = 0; i < 6; i++) step(seq[i], seq[i+1], 1'b1, 1'b1, 1'b0, $sformatf("frame%0d", i));

    step(mk_s(), mk_d(), 1'b1, 1'b1, 1'b0, "pre_bad_t");
    step(mk_t(0), mk_d(), 1'b1, 1'b1, 1'b0, "bad_t_next_d");
    step(mk_d(), mk_d(), 1'b1, 1'b1, 1'b0, "e_to_d");
    step({2'b11, $urandom, $urandom}, mk_d(), 1'b1, 1'b1, 1'b0, "sync11");
    step(mk_d(), mk_d(), 1'b1, 1'b1, 1'b0, "resume_d");
    step(mk_d(), mk_d(), 1'b1, 1'b0, 1'b0, "lock_drop");
    step(mk_s(), mk_d(), 1'b1, 1'b1, 1'b0, "relock_s");
    step(mk_d(), mk_d(), 1'b1, 1'b1, 1'b1, "hi_ber");

    step(mk_s(), mk_d(), 1'b1, 1'b1, 1'b0, "pre_reset_s");
    do_reset("reset_mid_frame");
    step(mk_d(), mk_d(), 1'b1, 1'b1, 1'b0, "after_reset_d");

    for (int i = 0; i < 5; i++)
      step(rand_block(), rand_block(), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $sformatf("frozen%0d", i));

    blk_n = rand_block();
    for (int i = 0; i < 400; i++) begin
      blk = blk_n;
      blk_n = rand_block();
      step(blk, blk_n, 1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 30) != 0),
           1'($urandom_range(0, 40) == 0), $sformatf("rand%0d", i));
    end

    for (int i = 0; i < 65540; i++) begin
      blk = {2'b00, $urandom, $urandom};
      cur = blk; nxt = blk; en = 1'b1; lock = 1'b1; ber = 1'b0;
      model_update(blk, blk, 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
    end
    check_all("saturated");
    step({2'b11, $urandom, $urandom}, mk_d(), 1'b1, 1'b1, 1'b0, "sat_hold");
    for (int i = 0; i < 5; i++)
      step(rand_block(), rand_block(), 1'b0, 1'b1, 1'b0, $sformatf("sat_frozen%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
